// File: rtl/wb_cpu_decoder.sv
// Single-master pipelined Wishbone address decoder with bus-error generation for unmapped addresses.
// Define WBDEC_TIMEOUT_EN to add a watchdog that turns a hung slave into a bus error after TIMEOUT cycles.
module wb_cpu_decoder #(
    parameter int               NS         = 4,
    parameter logic [NS*30-1:0] SLAVE_ADDR = {NS{30'h0}},
    parameter logic [NS*30-1:0] SLAVE_MASK = {NS{30'h0}},
    parameter int               TIMEOUT    = 1023
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_m_cyc,
    input  logic               i_m_stb,
    input  logic               i_m_we,
    input  logic [29:0]        i_m_addr,
    input  logic [31:0]        i_m_data,
    input  logic [3:0]         i_m_sel,
    output logic               o_m_stall,
    output logic               o_m_ack,
    output logic [31:0]        o_m_data,
    output logic               o_m_err,
    output logic [NS-1:0]      o_s_cyc,
    output logic [NS-1:0]      o_s_stb,
    output logic               o_s_we,
    output logic [29:0]        o_s_addr,
    output logic [31:0]        o_s_data,
    output logic [3:0]         o_s_sel,
    input  logic [NS-1:0]      i_s_stall,
    input  logic [NS-1:0]      i_s_ack,
    input  logic [NS-1:0]      i_s_err,
    input  logic [32*NS-1:0]   i_s_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [NS-1:0]   cyc_n, stb_n;
    logic            we_n;
    logic [29:0]     addr_n;
    logic [31:0]     wdata_n;
    logic [3:0]      sel_n;
    logic            ack_q, ack_n;
    logic            err_q, err_n;
    logic [31:0]     rdata_n;

    logic [NS-1:0]   match;
    logic [NS-1:0]   grant;
    logic [31:0]     slave_rdata;
    logic            ack_hit;
    logic            err_hit;
    logic            expired;

    // Address decode; the lowest-index match wins when masks overlap.
    always_comb begin
        match = '0;
        grant = '0;
        for (int k = 0; k < NS; k++) begin
            match[k] = ((i_m_addr & SLAVE_MASK[30*k +: 30]) == SLAVE_ADDR[30*k +: 30]);
        end
        for (int k = NS - 1; k >= 0; k--) begin
            if (match[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
            end
        end
    end

    // o_s_cyc is one-hot while busy, so it doubles as the return-path select.
    always_comb begin
        slave_rdata = '0;
        for (int k = 0; k < NS; k++) begin
            if (o_s_cyc[k]) begin
                slave_rdata = slave_rdata | i_s_data[32*k +: 32];
            end
        end
    end

    assign ack_hit = |(i_s_ack & o_s_cyc);
    assign err_hit = |(i_s_err & o_s_cyc);

`ifdef WBDEC_TIMEOUT_EN
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    logic [9:0] wd_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wd_cnt <= '0;
        end else if (state != BUSY) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 10'd1;
        end
    end

    assign expired = (state == BUSY) && (wd_cnt == WD_LAST);
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT);
    assign expired        = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cyc_n   = o_s_cyc;
        stb_n   = o_s_stb;
        we_n    = o_s_we;
        addr_n  = o_s_addr;
        wdata_n = o_s_data;
        sel_n   = o_s_sel;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        rdata_n = o_m_data;

        case (state)
            IDLE: begin
                if (i_m_cyc && i_m_stb) begin
                    we_n    = i_m_we;
                    addr_n  = i_m_addr;
                    wdata_n = i_m_data;
                    sel_n   = i_m_sel;
                    if (|match) begin
                        state_n = BUSY;
                        cyc_n   = grant;
                        stb_n   = grant;
                    end else begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
            end

            // Abort beats any response; a slave error beats an ack; any response beats the watchdog.
            BUSY: begin
                if (!i_m_cyc) begin
                    state_n = IDLE;
                    cyc_n   = '0;
                    stb_n   = '0;
                end else if (err_hit) begin
                    state_n = IDLE;
                    cyc_n   = '0;
                    stb_n   = '0;
                    err_n   = 1'b1;
                    rdata_n = slave_rdata;
                end else if (ack_hit) begin
                    state_n = IDLE;
                    cyc_n   = '0;
                    stb_n   = '0;
                    ack_n   = 1'b1;
                    rdata_n = slave_rdata;
                end else if (expired) begin
                    state_n = IDLE;
                    cyc_n   = '0;
                    stb_n   = '0;
                    err_n   = 1'b1;
                end else begin
                    stb_n = o_s_stb & i_s_stall;
                end
            end

            ERR: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
                cyc_n   = '0;
                stb_n   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            o_s_cyc  <= '0;
            o_s_stb  <= '0;
            o_s_we   <= 1'b0;
            o_s_addr <= '0;
            o_s_data <= '0;
            o_s_sel  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            o_m_data <= '0;
        end else begin
            state    <= state_n;
            o_s_cyc  <= cyc_n;
            o_s_stb  <= stb_n;
            o_s_we   <= we_n;
            o_s_addr <= addr_n;
            o_s_data <= wdata_n;
            o_s_sel  <= sel_n;
            ack_q    <= ack_n;
            err_q    <= err_n;
            o_m_data <= rdata_n;
        end
    end

    // Responses are suppressed once the master has closed its cycle.
    assign o_m_stall = (state != IDLE);
    assign o_m_ack   = ack_q & i_m_cyc;
    assign o_m_err   = err_q & i_m_cyc;

endmodule

// File: tb/tb_wb_cpu_decoder.sv
// Directed self-checking bench for wb_cpu_decoder: four slaves, one pair with overlapping windows.
// Expectations for the watchdog case follow WBDEC_TIMEOUT_EN when the build defines it.
module tb_wb_cpu_decoder;

    localparam int NS = 4;
    localparam logic [NS*30-1:0] S_ADDR = {30'h200_0000, 30'h000_0000, 30'h100_0000, 30'h000_0000};
    localparam logic [NS*30-1:0] S_MASK = {30'h3F0_0000, 30'h300_0000, 30'h3F0_0000, 30'h3F0_0000};

    logic              i_clk;
    logic              i_reset;
    logic              i_m_cyc, i_m_stb, i_m_we;
    logic [29:0]       i_m_addr;
    logic [31:0]       i_m_data;
    logic [3:0]        i_m_sel;
    logic              o_m_stall, o_m_ack, o_m_err;
    logic [31:0]       o_m_data;
    logic [NS-1:0]     o_s_cyc, o_s_stb;
    logic              o_s_we;
    logic [29:0]       o_s_addr;
    logic [31:0]       o_s_data;
    logic [3:0]        o_s_sel;
    logic [NS-1:0]     i_s_stall, i_s_ack, i_s_err;
    logic [32*NS-1:0]  i_s_data;

    int checks = 0;
    int errors = 0;

    wb_cpu_decoder #(
        .NS(NS),
        .SLAVE_ADDR(S_ADDR),
        .SLAVE_MASK(S_MASK),
        .TIMEOUT(8)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_m_cyc(i_m_cyc),
        .i_m_stb(i_m_stb),
        .i_m_we(i_m_we),
        .i_m_addr(i_m_addr),
        .i_m_data(i_m_data),
        .i_m_sel(i_m_sel),
        .o_m_stall(o_m_stall),
        .o_m_ack(o_m_ack),
        .o_m_data(o_m_data),
        .o_m_err(o_m_err),
        .o_s_cyc(o_s_cyc),
        .o_s_stb(o_s_stb),
        .o_s_we(o_s_we),
        .o_s_addr(o_s_addr),
        .o_s_data(o_s_data),
        .o_s_sel(o_s_sel),
        .i_s_stall(i_s_stall),
        .i_s_ack(i_s_ack),
        .i_s_err(i_s_err),
        .i_s_data(i_s_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [29:0] addr, input logic [31:0] data,
                                 input logic [3:0] sel, input logic [3:0] stall,
                                 input logic [3:0] ack, input logic [3:0] err);
        i_m_cyc   = cyc;
        i_m_stb   = stb;
        i_m_we    = we;
        i_m_addr  = addr;
        i_m_data  = data;
        i_m_sel   = sel;
        i_s_stall = stall;
        i_s_ack   = ack;
        i_s_err   = err;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        i_reset  = 1'b1;
        i_s_data = '0;
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        nextCycle();
        nextCycle();
        i_reset = 1'b0;
        #1;
        $display("[TB] reset values");
        checkOutput("rst_stall", 32'(o_m_stall), 32'h0);
        checkOutput("rst_cyc",   32'(o_s_cyc),   32'h0);
        checkOutput("rst_stb",   32'(o_s_stb),   32'h0);
        checkOutput("rst_ack",   32'(o_m_ack),   32'h0);
        checkOutput("rst_err",   32'(o_m_err),   32'h0);
        checkOutput("rst_mdata", o_m_data,       32'h0);
        checkOutput("rst_saddr", 32'(o_s_addr),  32'h0);
        checkOutput("rst_sdata", o_s_data,       32'h0);
        checkOutput("rst_ssel",  32'(o_s_sel),   32'h0);
        checkOutput("rst_swe",   32'(o_s_we),    32'h0);

        // Zero-wait read from slave 1
        $display("[TB] zero-wait read");
        i_s_data = {32'hCAFE0003, 32'h22222222, 32'hDEADBEEF, 32'h00000000};
        nextCycle();
        applyStimulus(1, 1, 0, 30'h100_0004, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        checkOutput("rd_c0_stall", 32'(o_m_stall), 32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'b0010, 4'h0);
        checkOutput("rd_c1_stb",   32'(o_s_stb),   32'h2);
        checkOutput("rd_c1_cyc",   32'(o_s_cyc),   32'h2);
        checkOutput("rd_c1_addr",  32'(o_s_addr),  32'h100_0004);
        checkOutput("rd_c1_stall", 32'(o_m_stall), 32'h1);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("rd_c2_ack",   32'(o_m_ack),   32'h1);
        checkOutput("rd_c2_data",  o_m_data,       32'hDEADBEEF);
        checkOutput("rd_c2_err",   32'(o_m_err),   32'h0);
        checkOutput("rd_c2_cyc",   32'(o_s_cyc),   32'h0);
        checkOutput("rd_c2_stall", 32'(o_m_stall), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("rd_c3_ack",   32'(o_m_ack),   32'h0);

        // Stalled write to slave 0 (slave 2 also matches, lower index wins)
        $display("[TB] stalled write");
        nextCycle();
        applyStimulus(1, 1, 1, 30'h000_0020, 32'h1234, 4'b0011, 4'b0001, 4'h0, 4'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h3AB_CDEF, 32'h5555_AAAA, 4'b1100, 4'b0001, 4'h0, 4'h0);
        checkOutput("wr_c1_stb",  32'(o_s_stb),  32'h1);
        checkOutput("wr_c1_we",   32'(o_s_we),   32'h1);
        checkOutput("wr_c1_sel",  32'(o_s_sel),  32'h3);
        checkOutput("wr_c1_data", o_s_data,      32'h1234);
        nextCycle();
        checkOutput("wr_c2_stb",  32'(o_s_stb),  32'h1);
        nextCycle();
        checkOutput("wr_c3_stb",  32'(o_s_stb),  32'h1);
        checkOutput("wr_c3_data", o_s_data,      32'h1234);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h3AB_CDEF, 32'h5555_AAAA, 4'b1100, 4'h0, 4'h0, 4'h0);
        checkOutput("wr_c4_stb",  32'(o_s_stb),  32'h1);
        nextCycle();
        checkOutput("wr_c5_stb",  32'(o_s_stb),  32'h0);
        checkOutput("wr_c5_cyc",  32'(o_s_cyc),  32'h1);
        checkOutput("wr_c5_ack",  32'(o_m_ack),  32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h3AB_CDEF, 32'h5555_AAAA, 4'b1100, 4'h0, 4'b0001, 4'h0);
        checkOutput("wr_c6_ack",  32'(o_m_ack),  32'h0);
        checkOutput("wr_c6_sel",  32'(o_s_sel),  32'h3);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("wr_c7_ack",  32'(o_m_ack),  32'h1);
        checkOutput("wr_c7_cyc",  32'(o_s_cyc),  32'h0);
        checkOutput("wr_c7_data", o_s_data,      32'h1234);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Unmapped address, then an immediate follow-on request to slave 3
        $display("[TB] unmapped address");
        nextCycle();
        applyStimulus(1, 1, 0, 30'h3FF_FFFF, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("um_c1_cyc",   32'(o_s_cyc),   32'h0);
        checkOutput("um_c1_err",   32'(o_m_err),   32'h1);
        checkOutput("um_c1_ack",   32'(o_m_ack),   32'h0);
        checkOutput("um_c1_stall", 32'(o_m_stall), 32'h1);
        nextCycle();
        applyStimulus(1, 1, 0, 30'h200_0040, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        checkOutput("um_c2_err",   32'(o_m_err),   32'h0);
        checkOutput("um_c2_stall", 32'(o_m_stall), 32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'b1000, 4'h0);
        checkOutput("um_c3_cyc",   32'(o_s_cyc),   32'h8);
        checkOutput("um_c3_stb",   32'(o_s_stb),   32'h8);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("um_c4_ack",   32'(o_m_ack),   32'h0);
        checkOutput("um_c4_data",  o_m_data,       32'hCAFE0003);

        // Overlap: slave 0 selected; err and ack together, err wins
        $display("[TB] overlap with slave error");
        nextCycle();
        applyStimulus(1, 1, 0, 30'h000_0010, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'b0101, 4'b0001);
        checkOutput("ov_c1_cyc", 32'(o_s_cyc), 32'h1);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("ov_c2_err", 32'(o_m_err), 32'h1);
        checkOutput("ov_c2_ack", 32'(o_m_ack), 32'h0);
        checkOutput("ov_c2_cyc", 32'(o_s_cyc), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("ov_c3_err", 32'(o_m_err), 32'h0);

        // Slave 2 alone matches; a foreign ack from slave 0 is ignored
        $display("[TB] foreign ack ignored");
        nextCycle();
        applyStimulus(1, 1, 0, 30'h050_0000, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'b0001, 4'h0);
        checkOutput("fa_c1_cyc", 32'(o_s_cyc), 32'h4);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'b0100, 4'h0);
        checkOutput("fa_c2_ack", 32'(o_m_ack), 32'h0);
        checkOutput("fa_c2_cyc", 32'(o_s_cyc), 32'h4);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("fa_c3_ack",  32'(o_m_ack), 32'h1);
        checkOutput("fa_c3_data", o_m_data,     32'h22222222);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Silent slave 1: watchdog fires after 8 busy cycles, or waits forever without it
        $display("[TB] silent slave");
        nextCycle();
        applyStimulus(1, 1, 0, 30'h100_0008, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("to_c1_cyc", 32'(o_s_cyc), 32'h2);
`ifdef WBDEC_TIMEOUT_EN
        repeat (7) nextCycle();
        checkOutput("to_c8_cyc", 32'(o_s_cyc), 32'h2);
        checkOutput("to_c8_err", 32'(o_m_err), 32'h0);
        nextCycle();
        checkOutput("to_c9_cyc",   32'(o_s_cyc),   32'h0);
        checkOutput("to_c9_err",   32'(o_m_err),   32'h1);
        checkOutput("to_c9_stall", 32'(o_m_stall), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
`else
        repeat (100) nextCycle();
        checkOutput("to_c101_stall", 32'(o_m_stall), 32'h1);
        checkOutput("to_c101_cyc",   32'(o_s_cyc),   32'h2);
        checkOutput("to_c101_err",   32'(o_m_err),   32'h0);
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        nextCycle();
        checkOutput("to_abort_cyc", 32'(o_s_cyc), 32'h0);
`endif

        // Master abort in BUSY followed by a late slave ack
        $display("[TB] master abort");
        nextCycle();
        applyStimulus(1, 1, 0, 30'h100_0010, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("ab_c1_cyc", 32'(o_s_cyc), 32'h2);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'b0010, 4'h0);
        checkOutput("ab_c2_cyc",   32'(o_s_cyc),   32'h0);
        checkOutput("ab_c2_stall", 32'(o_m_stall), 32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("ab_c3_ack", 32'(o_m_ack), 32'h0);
        checkOutput("ab_c3_err", 32'(o_m_err), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Reset while busy, then a late ack arriving in IDLE
        $display("[TB] reset in busy");
        nextCycle();
        applyStimulus(1, 1, 1, 30'h200_0100, 32'h9876_5432, 4'b1010, 4'h0, 4'h0, 4'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("rb_c1_cyc",  32'(o_s_cyc), 32'h8);
        checkOutput("rb_c1_data", o_s_data,     32'h9876_5432);
        i_reset = 1'b1;
        nextCycle();
        i_reset = 1'b0;
        applyStimulus(1, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'b1000, 4'h0);
        checkOutput("rb_c2_cyc",   32'(o_s_cyc),   32'h0);
        checkOutput("rb_c2_stb",   32'(o_s_stb),   32'h0);
        checkOutput("rb_c2_stall", 32'(o_m_stall), 32'h0);
        checkOutput("rb_c2_addr",  32'(o_s_addr),  32'h0);
        checkOutput("rb_c2_sdata", o_s_data,       32'h0);
        checkOutput("rb_c2_sel",   32'(o_s_sel),   32'h0);
        checkOutput("rb_c2_we",    32'(o_s_we),    32'h0);
        checkOutput("rb_c2_mdata", o_m_data,       32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 30'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("rb_c3_ack",   32'(o_m_ack),   32'h0);
        checkOutput("rb_c3_cyc",   32'(o_s_cyc),   32'h0);

        nextCycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_cpu_decoder.md
# wb_cpu_decoder

Single-master Wishbone address decoder and bus watchdog sitting directly downstream of the CPU's Wishbone master port. It accepts one pipelined-Wishbone request at a time and routes it to one of NS slaves by address/mask match. It returns the slave's ack, data or error to the CPU. Unmapped addresses and, optionally, hung slaves are converted into a bus error, which the CPU wrapper turns into IRQ 2.

## Interface
- NS, 4: number of slaves (1..8)
- SLAVE_ADDR, {NS{30'h0}}: concatenated 30-bit word base addresses; slave k uses bits [30k+:30]
- SLAVE_MASK, {NS{30'h0}}: concatenated 30-bit masks; slave k matches when (i_m_addr & mask_k) == addr_k
- TIMEOUT, 1023: watchdog limit in cycles (10-bit counter)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_m_cyc, i_m_stb, i_m_we  in  1 each  master cycle, strobe, write enable
- i_m_addr  in  30  master word address
- i_m_data  in  32  master write data
- i_m_sel  in  4  master byte selects
- o_m_stall  out  1  request not accepted this cycle
- o_m_ack  out  1  transaction complete
- o_m_data  out  32  read data, valid with o_m_ack
- o_m_err  out  1  bus error, one-cycle pulse
- o_s_cyc, o_s_stb  out  NS each  per-slave cycle and strobe
- o_s_we  out  1  shared write enable
- o_s_addr  out  30  shared address
- o_s_data  out  32  shared write data
- o_s_sel  out  4  shared byte selects
- i_s_stall, i_s_ack, i_s_err  in  NS each  per-slave stall, ack, error
- i_s_data  in  32*NS  per-slave read data, slave k on [32k+:32]

## Operation
- States: IDLE, BUSY, ERR.
- IDLE: o_m_stall=0. When i_m_cyc && i_m_stb, the request is accepted.
  - Address, data, sel and we are registered onto o_s_*.
  - The match vector is computed. The lowest-index matching slave wins.
  - If any slave matches, go to BUSY with o_s_cyc[k]=o_s_stb[k]=1. Otherwise go to ERR.
- BUSY: o_m_stall=1.
  - o_s_stb[k] clears on the first cycle i_s_stall[k]=0.
  - On i_s_ack[k]: o_m_ack=1 and o_m_data=i_s_data[k] on the next cycle, o_s_cyc/stb cleared, return to IDLE.
  - On i_s_err[k], the same sequence applies with o_m_err=1 instead of o_m_ack.
  - If ack and err are both asserted in the same cycle, err wins.
  - Ack or err from a slave other than k is ignored.
- ERR: o_m_stall=1. o_m_err=1 for exactly one cycle, then return to IDLE.
- Master abort: if i_m_cyc=0 in BUSY or ERR, all o_s_cyc/stb clear on the next edge, state returns to IDLE, and no ack/err is issued.
- o_m_ack and o_m_err are never both high. Each is only high while the master cycle remains open.
- o_s_we/addr/data/sel update only in IDLE and are held stable through BUSY.

## Timing
- Reset values:
  - State IDLE.
  - o_s_cyc=o_s_stb=0, o_m_ack=o_m_err=0.
  - o_m_data=0 and o_s_addr/data/sel/we=0.
  - Watchdog counter 0.
  - o_m_stall follows the state combinationally, so it is 0 after reset.
- Forward latency: request accepted at edge N, so o_s_stb is high in cycle N+1.
- Return latency: slave ack in cycle M gives o_m_ack in cycle M+1.
- Minimum transaction (zero-stall slave, same-cycle ack): master stb in cycle 0, slave stb in cycle 1, o_m_ack in cycle 2. The next request is accepted in cycle 2 at the earliest.
- Unmapped address: accepted in cycle 0, o_m_err in cycle 1.
- Reset mid-transaction: all slave strobes drop at that edge. A late slave ack arriving in IDLE is ignored.

## Configuration
- WBDEC_TIMEOUT_EN defined:
  - A 10-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT with no ack/err, it behaves like a slave error: slave cyc/stb drop, o_m_err pulses next cycle, state returns to IDLE.
  - An ack in the same cycle as expiry wins.
- WBDEC_TIMEOUT_EN undefined: no counter, and BUSY waits indefinitely.

## Test plan
- Zero-wait read: SLAVE_ADDR slave1=30'h100_0000 with mask 30'h3F0_0000. Read addr 30'h100_0004, slave acks in the first strobe cycle with 32'hDEADBEEF -> o_s_stb[1] high in cycle 1, o_m_ack with o_m_data=32'hDEADBEEF in cycle 2, other o_s_cyc low.
- Stalled write: slave0 stalls 3 cycles, then acks 2 cycles later, with sel=4'b0011 and data=32'h1234 -> o_s_stb held 4 cycles, o_s_sel/data stable throughout, o_m_ack one cycle after the slave ack.
- Unmapped address 30'h3FF_FFFF -> no o_s_cyc, o_m_err pulses in cycle 1, then the next request is accepted.
- Overlapping masks, slaves 0 and 2 both match -> slave 0 selected; slave err -> o_m_err, no o_m_ack.
- Timeout (macro defined, TIMEOUT=8), slave never acks -> o_s_cyc drops after 8 BUSY cycles, o_m_err the following cycle. Without the macro, still BUSY after 100 cycles.
- Master drops i_m_cyc in BUSY, then the slave acks -> o_s_cyc low next cycle, no o_m_ack. Reset in BUSY -> all outputs at reset values next cycle.
